// File: rtl/mips_trace_buffer_pkg.sv
// Shared definitions for the MIPS commit-trace capture block.
// Latency: n/a (constants and helper function only).
// Backpressure: n/a.
package mips_debug_pkg;

  // Capture FSM state encodings
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // rd_kind encodings: {MemWrite, RegWrite}
  localparam logic [1:0] KIND_REG = 2'b01;
  localparam logic [1:0] KIND_MEM = 2'b10;

  // Entry layout, MSB to LSB: {pc, data, reg[4:0], MemWrite, RegWrite}
  function automatic int entry_width(input int pc_w, input int data_w);
    return pc_w + data_w + 5 + 2;
  endfunction

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Drain port of the trace buffer: one entry per valid/ready handshake.
// Latency: n/a (wiring only).
// Backpressure: producer holds all rd_* fields while rd_valid & !rd_ready.
interface mips_trace_buffer_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);
  logic              rd_valid;
  logic              rd_ready;
  logic [PC_W-1:0]   rd_pc;
  logic [DATA_W-1:0] rd_data;
  logic [4:0]        rd_reg;
  logic [1:0]        rd_kind;

  modport master (output rd_valid, rd_pc, rd_data, rd_reg, rd_kind, input rd_ready);
  modport slave  (input rd_valid, rd_pc, rd_data, rd_reg, rd_kind, output rd_ready);
endinterface

// File: rtl/mips_trace_buffer_ram.sv
// Trace entry storage: DEPTH x WIDTH, one synchronous write, one async read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller owns all pointer bookkeeping.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 71,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one entry per enabled edge; contents need no reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_trace_buffer.sv
// Commit-trace capture: rolling pre-trigger history plus POST_DEPTH entries from a PC match.
// Latency: capture registered (visible after the sampling edge); drain read is combinational.
// Backpressure: rd_* held stable while rd_valid & !rd_ready; at most one pop per cycle.
module mips_trace_buffer
  import mips_debug_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int POST_DEPTH = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [PC_W-1:0]   trig_pc,
  input  logic [PC_W-1:0]   pc_out,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        write_register,
  input  logic              RegWrite,
  input  logic              MemWrite,
  mips_trace_buffer_if.master rd,
  output logic [1:0]        state,
  output logic [CW-1:0]     count,
  output logic              overflow
);

  localparam int EW = entry_width(PC_W, DATA_W);

  logic [1:0]    state_nx;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] post_cnt;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;
  logic          event_hit;
  logic          trig_hit;
  logic          full;
  logic          cap_en;
  logic          pop;

  assign event_hit = RegWrite | MemWrite;
  assign trig_hit  = (pc_out == trig_pc);
  assign full      = (count == CW'(DEPTH));
  // Write pointer is implied by read pointer + occupancy; when full it lands on the oldest entry
  assign wptr      = rptr + count[AW-1:0];
  // arm wins over any capture or pop in the same cycle
  assign cap_en    = event_hit && !arm && (state == ARMED || state == CAPTURE);
  assign pop       = (state == DONE) && (count != '0) && rd.rd_ready && !arm;
  assign wdata     = {pc_out, write_data, write_register, MemWrite, RegWrite};

  trace_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
    .clk   (clk),
    .we    (cap_en),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: arm restarts from any state; trigger may jump straight to DONE when POST_DEPTH=1
  always_comb begin
    state_nx = state;
    if (arm) begin
      state_nx = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (trig_hit) begin
            if (event_hit && POST_DEPTH == 1) state_nx = DONE;
            else                              state_nx = CAPTURE;
          end
        end
        CAPTURE: begin
          if (event_hit && post_cnt == CW'(1)) state_nx = DONE;
        end
        DONE: begin
          if (pop && count == CW'(1)) state_nx = IDLE;
        end
        default: state_nx = state;
      endcase
    end
  end

  // Drain port outputs: entry at the read pointer, valid only while draining
  always_comb begin
    rd.rd_valid = (state == DONE) && (count != '0);
    rd.rd_pc    = rdata[7+DATA_W +: PC_W];
    rd.rd_data  = rdata[7 +: DATA_W];
    rd.rd_reg   = rdata[2 +: 5];
    rd.rd_kind  = rdata[1:0];
  end

  // Pointers, occupancy, sticky overflow and post-trigger countdown
  always_ff @(posedge clk) begin
    if (reset || arm) begin
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_cnt <= '0;
    end else begin
      if (cap_en) begin
        if (full) begin
          rptr     <= rptr + 1'b1;
          overflow <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else if (pop) begin
        rptr  <= rptr + 1'b1;
        count <= count - 1'b1;
      end
      if (state == ARMED && trig_hit) begin
        post_cnt <= CW'(POST_DEPTH) - CW'(event_hit);
      end else if (state == CAPTURE && event_hit) begin
        post_cnt <= post_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed self-checking bench for mips_trace_buffer (DEPTH=8, POST_DEPTH=4).
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: exercises rd_ready held high and toggling.
module tb_mips_trace_buffer;
  import mips_debug_pkg::*;

  localparam int DEPTH = 8;
  localparam int POST  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic [31:0] trig_pc;
  logic [31:0] pc_out;
  logic [31:0] write_data;
  logic [4:0]  write_register;
  logic        RegWrite;
  logic        MemWrite;
  logic [1:0]  state;
  logic [3:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_trace_buffer_if #(.PC_W(32), .DATA_W(32)) rd_if ();

  mips_trace_buffer #(.PC_W(32), .DATA_W(32), .DEPTH(DEPTH), .POST_DEPTH(POST)) dut (
    .clk            (clk),
    .reset          (reset),
    .arm            (arm),
    .trig_pc        (trig_pc),
    .pc_out         (pc_out),
    .write_data     (write_data),
    .write_register (write_register),
    .RegWrite       (RegWrite),
    .MemWrite       (MemWrite),
    .rd             (rd_if),
    .state          (state),
    .count          (count),
    .overflow       (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm            = 1'b0;
    RegWrite       = 1'b0;
    MemWrite       = 1'b0;
    pc_out         = 32'hFFFF_FFF0;
    write_data     = '0;
    write_register = '0;
  endtask

  task automatic ev(input logic [31:0] pc, input logic [31:0] d, input logic [4:0] r,
                    input logic [1:0] k);
    pc_out         = pc;
    write_data     = d;
    write_register = r;
    {MemWrite, RegWrite} = k;
    tick();
    idle_inputs();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++;
    if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rd_if.rd_valid); end
    checks++;
    trig_pc = 32'h100;
    do_arm();
    ev(32'h0, 32'h1, 5'd1, KIND_REG);
    ev(32'h4, 32'h2, 5'd2, KIND_REG);
    ev(32'h8, 32'h3, 5'd3, KIND_REG);
    ev(32'hC, 32'h4, 5'd4, KIND_REG);
    ev(32'h100, 32'h5, 5'd5, KIND_REG);
    if (state !== CAPTURE || count !== 4'd5) begin
      errors++; $display("FAIL midcap_setup got state %0d count %0d exp 2/5", state, count);
    end
    checks++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (state !== 2'd0) begin errors++; $display("FAIL midreset_state got %0d exp 0", state); end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL midreset_count got %0d exp 0", count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL midreset_ovf got %b exp 0", overflow); end
    checks++;
    if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", rd_if.rd_valid); end
    checks++;
  endtask

  task automatic test_basic_capture();
    trig_pc = 32'hC;
    do_arm();
    for (int i = 0; i < 7; i++) begin
      ev(32'(4 * i), 32'(4 * i + 32'h100), 5'(i + 1), KIND_REG);
      if (i == 3 && state !== CAPTURE) begin
        errors++; $display("FAIL basic_trig_state got %0d exp 2", state);
      end
      if (i == 3) checks++;
    end
    if (state !== DONE) begin errors++; $display("FAIL basic_done got %0d exp 3", state); end
    checks++;
    if (count !== 4'd7) begin errors++; $display("FAIL basic_count got %0d exp 7", count); end
    checks++;
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_pc !== 32'(4 * i) || rd_if.rd_data !== 32'(4 * i + 32'h100)) begin
        errors++;
        $display("FAIL basic_drain[%0d] got v=%b pc=%h d=%h exp v=1 pc=%h d=%h", i,
                 rd_if.rd_valid, rd_if.rd_pc, rd_if.rd_data, 32'(4 * i), 32'(4 * i + 32'h100));
      end
      checks++;
      tick();
    end
    rd_if.rd_ready = 1'b0;
    if (state !== IDLE || count !== 4'd0 || rd_if.rd_valid !== 1'b0) begin
      errors++; $display("FAIL basic_idle got state %0d count %0d v %b exp 0/0/0", state, count, rd_if.rd_valid);
    end
    checks++;
  endtask

  task automatic test_overflow();
    trig_pc = 32'h50;
    do_arm();
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    checks++;
    for (int i = 0; i < 24; i++) ev(32'(4 * i), 32'(4 * i) ^ 32'hA5A5_0000, 5'(i), KIND_REG);
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++;
    if (count !== 4'd8 || state !== DONE) begin
      errors++; $display("FAIL ovf_count got count %0d state %0d exp 8/3", count, state);
    end
    checks++;
    if (rd_if.rd_pc !== 32'h40) begin errors++; $display("FAIL ovf_first_pc got %h exp 00000040", rd_if.rd_pc); end
    checks++;
  endtask

  task automatic test_toggle_drain();
    int n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      rd_if.rd_ready = (c % 2 == 0);
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_pc !== 32'(32'h40 + 4 * n) ||
          rd_if.rd_data !== (32'(32'h40 + 4 * n) ^ 32'hA5A5_0000)) begin
        errors++;
        $display("FAIL toggle_drain[%0d] got v=%b pc=%h d=%h exp v=1 pc=%h", n,
                 rd_if.rd_valid, rd_if.rd_pc, rd_if.rd_data, 32'(32'h40 + 4 * n));
      end
      checks++;
      if (rd_if.rd_ready) n++;
      tick();
    end
    rd_if.rd_ready = 1'b0;
    if (n !== 8) begin errors++; $display("FAIL toggle_timeout got %0d pops exp 8", n); end
    checks++;
    if (state !== IDLE || count !== 4'd0) begin
      errors++; $display("FAIL toggle_idle got state %0d count %0d exp 0/0", state, count);
    end
    checks++;
  endtask

  task automatic test_kinds();
    logic [31:0] exp_pc [5];
    logic [1:0]  exp_k  [5];
    logic [4:0]  exp_r  [5];
    exp_pc[0] = 32'h1F0; exp_k[0] = KIND_REG; exp_r[0] = 5'd1;
    exp_pc[1] = 32'h204; exp_k[1] = KIND_REG; exp_r[1] = 5'd2;
    exp_pc[2] = 32'h200; exp_k[2] = KIND_REG; exp_r[2] = 5'd3;
    exp_pc[3] = 32'h208; exp_k[3] = KIND_MEM; exp_r[3] = 5'd4;
    exp_pc[4] = 32'h20C; exp_k[4] = KIND_REG; exp_r[4] = 5'd5;
    trig_pc = 32'h200;
    do_arm();
    if (state !== ARMED || overflow !== 1'b0) begin
      errors++; $display("FAIL kinds_armed got state %0d ovf %b exp 1/0", state, overflow);
    end
    checks++;
    ev(exp_pc[0], 32'hD0, exp_r[0], exp_k[0]);
    ev(32'h200, 32'h0, 5'd0, 2'b00);
    if (state !== CAPTURE || count !== 4'd1) begin
      errors++; $display("FAIL kinds_trig got state %0d count %0d exp 2/1", state, count);
    end
    checks++;
    for (int i = 1; i < 5; i++) begin
      ev(exp_pc[i], 32'(32'hD0 + i), exp_r[i], exp_k[i]);
      if (i < 4 && state !== CAPTURE) begin
        errors++; $display("FAIL kinds_capture[%0d] got state %0d exp 2", i, state);
      end
      if (i < 4) checks++;
    end
    if (state !== DONE || count !== 4'd5) begin
      errors++; $display("FAIL kinds_done got state %0d count %0d exp 3/5", state, count);
    end
    checks++;
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rd_if.rd_pc !== exp_pc[i] || rd_if.rd_kind !== exp_k[i] || rd_if.rd_reg !== exp_r[i]) begin
        errors++;
        $display("FAIL kinds_drain[%0d] got pc=%h k=%b r=%0d exp pc=%h k=%b r=%0d", i,
                 rd_if.rd_pc, rd_if.rd_kind, rd_if.rd_reg, exp_pc[i], exp_k[i], exp_r[i]);
      end
      checks++;
      tick();
    end
    rd_if.rd_ready = 1'b0;
  endtask

  task automatic test_rearm();
    logic [31:0] exp_pc [5];
    exp_pc[0] = 32'h400; exp_pc[1] = 32'h300; exp_pc[2] = 32'h404;
    exp_pc[3] = 32'h408; exp_pc[4] = 32'h40C;
    trig_pc = 32'h300;
    do_arm();
    ev(32'h2F0, 32'h1, 5'd1, KIND_REG);
    ev(32'h2F4, 32'h2, 5'd2, KIND_REG);
    ev(32'h300, 32'h3, 5'd3, KIND_REG);
    ev(32'h304, 32'h4, 5'd4, KIND_MEM);
    ev(32'h308, 32'h5, 5'd5, KIND_REG);
    ev(32'h30C, 32'h6, 5'd6, KIND_REG);
    if (state !== DONE || count !== 4'd6) begin
      errors++; $display("FAIL rearm_setup got state %0d count %0d exp 3/6", state, count);
    end
    checks++;
    rd_if.rd_ready = 1'b1;
    arm = 1'b1;
    ev(32'h2EC, 32'h7, 5'd7, KIND_REG);
    rd_if.rd_ready = 1'b0;
    if (count !== 4'd0) begin errors++; $display("FAIL rearm_count got %0d exp 0", count); end
    checks++;
    if (state !== ARMED || rd_if.rd_valid !== 1'b0) begin
      errors++; $display("FAIL rearm_state got state %0d v %b exp 1/0", state, rd_if.rd_valid);
    end
    checks++;
    for (int i = 0; i < 5; i++) ev(exp_pc[i], 32'h10 + 32'(i), 5'(i), KIND_REG);
    if (state !== DONE || count !== 4'd5) begin
      errors++; $display("FAIL rearm_done got state %0d count %0d exp 3/5", state, count);
    end
    checks++;
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL rearm_drain[%0d] got v=%b pc=%h exp v=1 pc=%h", i, rd_if.rd_valid, rd_if.rd_pc, exp_pc[i]);
      end
      checks++;
      tick();
    end
    rd_if.rd_ready = 1'b0;
    if (state !== IDLE) begin errors++; $display("FAIL rearm_idle got %0d exp 0", state); end
    checks++;
  endtask

  initial begin
    reset          = 1'b1;
    trig_pc        = 32'hFFFF_FFFC;
    rd_if.rd_ready = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_basic_capture();
    test_overflow();
    test_toggle_drain();
    test_kinds();
    test_rearm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
